// File: rtl/id_ex_stage_reg_pkg.sv
// Shared constants and control bundle for the ID/EX pipeline register.
// Widths default to the 32-bit / 32-register datapath.
package id_ex_stage_reg_pkg;

  localparam int         DW_DEF      = 32;
  localparam int         AW_DEF      = 5;
  localparam logic [5:0] NOP_FUN_DEF = 6'b000000;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC  = 2'd2
  } mem_to_reg_e;

  typedef struct packed {
    logic        alu_src1;
    logic        alu_src2;
    logic        sign;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [5:0]  alu_fun;
    mem_to_reg_e mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result, register 0 is never forwarded.
// Purely combinational; no state, no backpressure.
module fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_addr,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_dat,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_dat,
  input  logic [DW-1:0] reg_dat,
  output logic [DW-1:0] fwd_dat
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_wr_addr != '0) && (mem_wr_addr == src_addr);
  assign wb_hit  = wb_reg_write  && (wb_wr_addr  != '0) && (wb_wr_addr  == src_addr);

  always_comb begin
    fwd_dat = reg_dat;
    if (mem_hit) begin
      fwd_dat = mem_dat;
    end else if (wb_hit) begin
      fwd_dat = wb_dat;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detection; 1-cycle ID->EX.
// MEM_Stall freezes everything; branch flush or load-use inserts a single bubble.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int         DW      = DW_DEF,
  parameter int         AW      = AW_DEF,
  parameter logic [5:0] NOP_FUN = NOP_FUN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ID_PC,
  input  logic [4:0]    ID_Shamt,
  input  logic [DW-1:0] ID_DatabusA,
  input  logic [DW-1:0] ID_DatabusB,
  input  logic [DW-1:0] ID_Ext_out,
  input  logic [DW-1:0] ID_LU_out,
  input  logic [AW-1:0] ID_Rs,
  input  logic [AW-1:0] ID_Rt,
  input  logic [AW-1:0] ID_WrAddr,
  input  logic          ID_ALUSrc1,
  input  logic          ID_ALUSrc2,
  input  logic          ID_Sign,
  input  logic          ID_Branch,
  input  logic          ID_MemRead,
  input  logic          ID_MemWrite,
  input  logic          ID_RegWrite,
  input  logic [5:0]    ID_ALUFun,
  input  logic [1:0]    ID_MemToReg,
  input  logic          MEM_Stall,
  input  logic          EX_Branch_EN,
  input  logic          MEM_RegWrite,
  input  logic [AW-1:0] MEM_WrAddr,
  input  logic [DW-1:0] MEM_ALU_out,
  input  logic          WB_RegWrite,
  input  logic [AW-1:0] WB_WrAddr,
  input  logic [DW-1:0] WB_DatabusC,
  output logic [DW-1:0] EX_PC,
  output logic [4:0]    EX_Shamt,
  output logic [DW-1:0] EX_DatabusA,
  output logic [DW-1:0] EX_DatabusB,
  output logic [DW-1:0] EX_Ext_out,
  output logic [DW-1:0] EX_LU_out,
  output logic [AW-1:0] EX_Rs,
  output logic [AW-1:0] EX_Rt,
  output logic [AW-1:0] EX_WrAddr,
  output logic          EX_ALUSrc1,
  output logic          EX_ALUSrc2,
  output logic          EX_Sign,
  output logic          EX_Branch,
  output logic          EX_MemRead,
  output logic          EX_MemWrite,
  output logic          EX_RegWrite,
  output logic [5:0]    EX_ALUFun,
  output logic [1:0]    EX_MemToReg,
  output logic          EX_Valid,
  output logic          Load_Use_Stall
);

  logic [DW-1:0] pc_q, pc_d, data_a_q, data_a_d, data_b_q, data_b_d;
  logic [DW-1:0] ext_q, ext_d, lu_q, lu_d;
  logic [4:0]    shamt_q, shamt_d;
  logic [AW-1:0] rs_q, rs_d, rt_q, rt_d, wr_addr_q, wr_addr_d;
  ctrl_t         ctrl_q, ctrl_d, id_ctrl;
  logic          valid_q, valid_d;
  logic          load_use;

  always_comb begin
    id_ctrl            = '0;
    id_ctrl.alu_src1   = ID_ALUSrc1;
    id_ctrl.alu_src2   = ID_ALUSrc2;
    id_ctrl.sign       = ID_Sign;
    id_ctrl.branch     = ID_Branch;
    id_ctrl.mem_read   = ID_MemRead;
    id_ctrl.mem_write  = ID_MemWrite;
    id_ctrl.reg_write  = ID_RegWrite;
    id_ctrl.alu_fun    = ID_ALUFun;
    id_ctrl.mem_to_reg = mem_to_reg_e'(ID_MemToReg);
  end

  // A bubble already in EX has MemRead cleared, so it can never re-trigger a stall.
  assign load_use = !MEM_Stall && valid_q && ctrl_q.mem_read && (wr_addr_q != '0)
                    && ((wr_addr_q == ID_Rs) || (wr_addr_q == ID_Rt));

  always_comb begin
    pc_d      = pc_q;
    shamt_d   = shamt_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    ext_d     = ext_q;
    lu_d      = lu_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    wr_addr_d = wr_addr_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    if (!MEM_Stall) begin
      pc_d      = ID_PC;
      shamt_d   = ID_Shamt;
      data_a_d  = ID_DatabusA;
      data_b_d  = ID_DatabusB;
      ext_d     = ID_Ext_out;
      lu_d      = ID_LU_out;
      rs_d      = ID_Rs;
      rt_d      = ID_Rt;
      wr_addr_d = ID_WrAddr;
      ctrl_d    = id_ctrl;
      valid_d   = 1'b1;
      // Bubble kills side effects only; data/PC stay loaded for debug visibility.
      if (EX_Branch_EN || load_use) begin
        ctrl_d.reg_write = 1'b0;
        ctrl_d.mem_read  = 1'b0;
        ctrl_d.mem_write = 1'b0;
        ctrl_d.branch    = 1'b0;
        ctrl_d.alu_fun   = NOP_FUN;
        wr_addr_d        = '0;
        valid_d          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      shamt_q   <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      ext_q     <= '0;
      lu_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_addr_q <= '0;
      ctrl_q    <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP_FUN, MTR_ALU};
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      shamt_q   <= shamt_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      ext_q     <= ext_d;
      lu_q      <= lu_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      wr_addr_q <= wr_addr_d;
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
    end
  end

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src_addr      (rs_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_wr_addr   (MEM_WrAddr),
    .mem_dat       (MEM_ALU_out),
    .wb_reg_write  (WB_RegWrite),
    .wb_wr_addr    (WB_WrAddr),
    .wb_dat        (WB_DatabusC),
    .reg_dat       (data_a_q),
    .fwd_dat       (EX_DatabusA)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src_addr      (rt_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_wr_addr   (MEM_WrAddr),
    .mem_dat       (MEM_ALU_out),
    .wb_reg_write  (WB_RegWrite),
    .wb_wr_addr    (WB_WrAddr),
    .wb_dat        (WB_DatabusC),
    .reg_dat       (data_b_q),
    .fwd_dat       (EX_DatabusB)
  );

  assign EX_PC          = pc_q;
  assign EX_Shamt       = shamt_q;
  assign EX_Ext_out     = ext_q;
  assign EX_LU_out      = lu_q;
  assign EX_Rs          = rs_q;
  assign EX_Rt          = rt_q;
  assign EX_WrAddr      = wr_addr_q;
  assign EX_ALUSrc1     = ctrl_q.alu_src1;
  assign EX_ALUSrc2     = ctrl_q.alu_src2;
  assign EX_Sign        = ctrl_q.sign;
  assign EX_Branch      = ctrl_q.branch;
  assign EX_MemRead     = ctrl_q.mem_read;
  assign EX_MemWrite    = ctrl_q.mem_write;
  assign EX_RegWrite    = ctrl_q.reg_write;
  assign EX_ALUFun      = ctrl_q.alu_fun;
  assign EX_MemToReg    = ctrl_q.mem_to_reg;
  assign EX_Valid       = valid_q;
  assign Load_Use_Stall = load_use;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, forwarding, load-use, flush and stall scenarios.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ID_PC, ID_DatabusA, ID_DatabusB, ID_Ext_out, ID_LU_out;
  logic [4:0]  ID_Shamt, ID_Rs, ID_Rt, ID_WrAddr;
  logic        ID_ALUSrc1, ID_ALUSrc2, ID_Sign, ID_Branch, ID_MemRead, ID_MemWrite, ID_RegWrite;
  logic [5:0]  ID_ALUFun;
  logic [1:0]  ID_MemToReg;
  logic        MEM_Stall, EX_Branch_EN, MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_WrAddr, WB_WrAddr;
  logic [31:0] MEM_ALU_out, WB_DatabusC;
  logic [31:0] EX_PC, EX_DatabusA, EX_DatabusB, EX_Ext_out, EX_LU_out;
  logic [4:0]  EX_Shamt, EX_Rs, EX_Rt, EX_WrAddr;
  logic        EX_ALUSrc1, EX_ALUSrc2, EX_Sign, EX_Branch, EX_MemRead, EX_MemWrite, EX_RegWrite;
  logic [5:0]  EX_ALUFun;
  logic [1:0]  EX_MemToReg;
  logic        EX_Valid, Load_Use_Stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset),
    .ID_PC(ID_PC), .ID_Shamt(ID_Shamt), .ID_DatabusA(ID_DatabusA), .ID_DatabusB(ID_DatabusB),
    .ID_Ext_out(ID_Ext_out), .ID_LU_out(ID_LU_out), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_WrAddr(ID_WrAddr), .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2), .ID_Sign(ID_Sign),
    .ID_Branch(ID_Branch), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_RegWrite(ID_RegWrite), .ID_ALUFun(ID_ALUFun), .ID_MemToReg(ID_MemToReg),
    .MEM_Stall(MEM_Stall), .EX_Branch_EN(EX_Branch_EN),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WrAddr(MEM_WrAddr), .MEM_ALU_out(MEM_ALU_out),
    .WB_RegWrite(WB_RegWrite), .WB_WrAddr(WB_WrAddr), .WB_DatabusC(WB_DatabusC),
    .EX_PC(EX_PC), .EX_Shamt(EX_Shamt), .EX_DatabusA(EX_DatabusA), .EX_DatabusB(EX_DatabusB),
    .EX_Ext_out(EX_Ext_out), .EX_LU_out(EX_LU_out), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_WrAddr(EX_WrAddr), .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2), .EX_Sign(EX_Sign),
    .EX_Branch(EX_Branch), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_RegWrite(EX_RegWrite), .EX_ALUFun(EX_ALUFun), .EX_MemToReg(EX_MemToReg),
    .EX_Valid(EX_Valid), .Load_Use_Stall(Load_Use_Stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wr, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] fun, input logic regw, input logic memr,
                          input logic memw);
    ID_PC       = pc;
    ID_Shamt    = rs;
    ID_DatabusA = a;
    ID_DatabusB = b;
    ID_Ext_out  = pc + 32'd1;
    ID_LU_out   = pc << 16;
    ID_Rs       = rs;
    ID_Rt       = rt;
    ID_WrAddr   = wr;
    ID_ALUSrc1  = 1'b0;
    ID_ALUSrc2  = memr | memw;
    ID_Sign     = 1'b1;
    ID_Branch   = 1'b0;
    ID_MemRead  = memr;
    ID_MemWrite = memw;
    ID_RegWrite = regw;
    ID_ALUFun   = fun;
    ID_MemToReg = memr ? 2'd1 : 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_id(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    MEM_Stall = 0; EX_Branch_EN = 0;
    MEM_RegWrite = 0; MEM_WrAddr = 0; MEM_ALU_out = 0;
    WB_RegWrite = 0; WB_WrAddr = 0; WB_DatabusC = 0;
    tick(); tick();
    n_cmp++; if (EX_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", EX_Valid); end
    n_cmp++; if (EX_PC !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", EX_PC); end
    n_cmp++; if (EX_ALUFun !== 6'h0) begin n_err++; $display("FAIL rst_alufun: got %h want 0", EX_ALUFun); end
    n_cmp++; if (EX_RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %0b want 0", EX_RegWrite); end
    n_cmp++; if (Load_Use_Stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", Load_Use_Stall); end
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    drive_id(32'h40, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 6'h21, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b want 1", EX_Valid); end
    n_cmp++; if (EX_PC !== 32'h40) begin n_err++; $display("FAIL basic_pc: got %h want 40", EX_PC); end
    n_cmp++; if (EX_DatabusA !== 32'h1234) begin n_err++; $display("FAIL basic_a: got %h want 1234", EX_DatabusA); end
    n_cmp++; if (EX_DatabusB !== 32'h5678) begin n_err++; $display("FAIL basic_b: got %h want 5678", EX_DatabusB); end
    n_cmp++; if (EX_Ext_out !== 32'h41) begin n_err++; $display("FAIL basic_ext: got %h want 41", EX_Ext_out); end
    n_cmp++; if (EX_LU_out !== 32'h0040_0000) begin n_err++; $display("FAIL basic_lu: got %h want 400000", EX_LU_out); end
    n_cmp++; if (EX_WrAddr !== 5'd3) begin n_err++; $display("FAIL basic_wr: got %0d want 3", EX_WrAddr); end
    n_cmp++; if (EX_ALUFun !== 6'h21) begin n_err++; $display("FAIL basic_fun: got %h want 21", EX_ALUFun); end
    n_cmp++; if (EX_RegWrite !== 1'b1) begin n_err++; $display("FAIL basic_regw: got %0b want 1", EX_RegWrite); end
    n_cmp++; if (EX_Sign !== 1'b1) begin n_err++; $display("FAIL basic_sign: got %0b want 1", EX_Sign); end
  endtask

  task automatic test_forward();
    drive_id(32'h80, 5'd5, 5'd6, 5'd7, 32'hAAAA, 32'hBBBB, 6'h0, 1'b1, 1'b0, 1'b0);
    tick();
    MEM_RegWrite = 1; MEM_WrAddr = 5'd5; MEM_ALU_out = 32'h11;
    WB_RegWrite = 1; WB_WrAddr = 5'd5; WB_DatabusC = 32'h22;
    #1;
    n_cmp++; if (EX_DatabusA !== 32'h11) begin n_err++; $display("FAIL fwd_mem: got %h want 11", EX_DatabusA); end
    n_cmp++; if (EX_DatabusB !== 32'hBBBB) begin n_err++; $display("FAIL fwd_b_none: got %h want bbbb", EX_DatabusB); end
    MEM_RegWrite = 0;
    #1;
    n_cmp++; if (EX_DatabusA !== 32'h22) begin n_err++; $display("FAIL fwd_wb: got %h want 22", EX_DatabusA); end
    MEM_RegWrite = 1; MEM_WrAddr = 5'd0; WB_WrAddr = 5'd0;
    #1;
    n_cmp++; if (EX_DatabusA !== 32'hAAAA) begin n_err++; $display("FAIL fwd_r0: got %h want aaaa", EX_DatabusA); end
    MEM_RegWrite = 0; WB_WrAddr = 5'd6;
    #1;
    n_cmp++; if (EX_DatabusB !== 32'h22) begin n_err++; $display("FAIL fwd_wb_b: got %h want 22", EX_DatabusB); end
    n_cmp++; if (EX_DatabusA !== 32'hAAAA) begin n_err++; $display("FAIL fwd_a_none: got %h want aaaa", EX_DatabusA); end
    WB_RegWrite = 0; WB_WrAddr = 0;
  endtask

  task automatic test_load_use();
    drive_id(32'h100, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    n_cmp++; if (EX_MemRead !== 1'b1) begin n_err++; $display("FAIL lu_memread: got %0b want 1", EX_MemRead); end
    drive_id(32'h104, 5'd8, 5'd3, 5'd4, 32'h0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (Load_Use_Stall !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", Load_Use_Stall); end
    tick();
    n_cmp++; if (EX_Valid !== 1'b0) begin n_err++; $display("FAIL lu_bub_valid: got %0b want 0", EX_Valid); end
    n_cmp++; if (EX_RegWrite !== 1'b0) begin n_err++; $display("FAIL lu_bub_regw: got %0b want 0", EX_RegWrite); end
    n_cmp++; if (EX_WrAddr !== 5'd0) begin n_err++; $display("FAIL lu_bub_wr: got %0d want 0", EX_WrAddr); end
    n_cmp++; if (EX_PC !== 32'h104) begin n_err++; $display("FAIL lu_bub_pc: got %h want 104", EX_PC); end
    n_cmp++; if (Load_Use_Stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_clr: got %0b want 0", Load_Use_Stall); end
    tick();
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL lu_dep_valid: got %0b want 1", EX_Valid); end
    n_cmp++; if (EX_WrAddr !== 5'd4) begin n_err++; $display("FAIL lu_dep_wr: got %0d want 4", EX_WrAddr); end
  endtask

  task automatic test_flush();
    drive_id(32'h500, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 6'h21, 1'b1, 1'b0, 1'b1);
    EX_Branch_EN = 1;
    tick();
    n_cmp++; if (EX_Valid !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %0b want 0", EX_Valid); end
    n_cmp++; if (EX_RegWrite !== 1'b0) begin n_err++; $display("FAIL fl_regw: got %0b want 0", EX_RegWrite); end
    n_cmp++; if (EX_MemWrite !== 1'b0) begin n_err++; $display("FAIL fl_memw: got %0b want 0", EX_MemWrite); end
    n_cmp++; if (EX_ALUFun !== 6'h0) begin n_err++; $display("FAIL fl_fun: got %h want 0", EX_ALUFun); end
    n_cmp++; if (EX_PC !== 32'h500) begin n_err++; $display("FAIL fl_pc: got %h want 500", EX_PC); end
    EX_Branch_EN = 0;
    drive_id(32'h504, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 6'h22, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL fl_next_valid: got %0b want 1", EX_Valid); end
    n_cmp++; if (EX_ALUFun !== 6'h22) begin n_err++; $display("FAIL fl_next_fun: got %h want 22", EX_ALUFun); end
  endtask

  task automatic test_stall();
    drive_id(32'h200, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h204, 5'd3, 5'd9, 5'd4, 32'h0, 32'h0, 6'h0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (Load_Use_Stall !== 1'b1) begin n_err++; $display("FAIL st_rt_hazard: got %0b want 1", Load_Use_Stall); end
    MEM_Stall = 1;
    #1;
    n_cmp++; if (Load_Use_Stall !== 1'b0) begin n_err++; $display("FAIL st_mask: got %0b want 0", Load_Use_Stall); end
    for (int i = 0; i < 3; i++) begin
      drive_id(32'h300 + 32'(i * 4), 5'd9, 5'd9, 5'd11, 32'(i), 32'(i), 6'h3, 1'b1, 1'b0, 1'b1);
      tick();
      n_cmp++; if (EX_PC !== 32'h200) begin n_err++; $display("FAIL st_hold_pc: got %h want 200", EX_PC); end
      n_cmp++; if (EX_Valid !== 1'b1 || EX_MemRead !== 1'b1) begin n_err++; $display("FAIL st_hold_ctl: got valid %0b memread %0b want 1 1", EX_Valid, EX_MemRead); end
      n_cmp++; if (Load_Use_Stall !== 1'b0) begin n_err++; $display("FAIL st_stall_low: got %0b want 0", Load_Use_Stall); end
    end
    drive_id(32'h400, 5'd1, 5'd2, 5'd12, 32'h0, 32'h0, 6'h5, 1'b1, 1'b0, 1'b0);
    MEM_Stall = 0;
    tick();
    n_cmp++; if (EX_PC !== 32'h400) begin n_err++; $display("FAIL st_release_pc: got %h want 400", EX_PC); end
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL st_release_valid: got %0b want 1", EX_Valid); end
  endtask

  task automatic test_flush_loaduse();
    drive_id(32'h600, 5'd1, 5'd2, 5'd10, 32'h0, 32'h0, 6'h0, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(32'h604, 5'd10, 5'd2, 5'd13, 32'h0, 32'h0, 6'h23, 1'b1, 1'b0, 1'b0);
    EX_Branch_EN = 1;
    #1;
    n_cmp++; if (Load_Use_Stall !== 1'b1) begin n_err++; $display("FAIL flu_stall: got %0b want 1", Load_Use_Stall); end
    tick();
    n_cmp++; if (EX_Valid !== 1'b0) begin n_err++; $display("FAIL flu_bubble: got %0b want 0", EX_Valid); end
    EX_Branch_EN = 0;
    #1;
    n_cmp++; if (Load_Use_Stall !== 1'b0) begin n_err++; $display("FAIL flu_stall_clr: got %0b want 0", Load_Use_Stall); end
    tick();
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL flu_load_valid: got %0b want 1", EX_Valid); end
    n_cmp++; if (EX_ALUFun !== 6'h23) begin n_err++; $display("FAIL flu_load_fun: got %h want 23", EX_ALUFun); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    n_cmp++; if (EX_Valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %0b want 0", EX_Valid); end
    n_cmp++; if (EX_PC !== 32'h0) begin n_err++; $display("FAIL rm_pc: got %h want 0", EX_PC); end
    n_cmp++; if (EX_ALUFun !== 6'h0) begin n_err++; $display("FAIL rm_fun: got %h want 0", EX_ALUFun); end
    n_cmp++; if (EX_RegWrite !== 1'b0 || EX_WrAddr !== 5'd0) begin n_err++; $display("FAIL rm_ctl: got regw %0b wr %0d want 0 0", EX_RegWrite, EX_WrAddr); end
    tick();
    reset = 1'b0;
    drive_id(32'h700, 5'd1, 5'd2, 5'd14, 32'h0, 32'h0, 6'h7, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (EX_Valid !== 1'b1) begin n_err++; $display("FAIL rm_first_valid: got %0b want 1", EX_Valid); end
    n_cmp++; if (EX_PC !== 32'h700) begin n_err++; $display("FAIL rm_first_pc: got %h want 700", EX_PC); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_forward();
    test_load_use();
    test_flush();
    test_stall();
    test_flush_loaduse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
